// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches with credit-based
// flow control, buffers responses and hands {inst, pc} to decode; redirects flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] WORD_MSK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_RST   = RESET_PC & WORD_MSK;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t           fifo_q [DEPTH];
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic             req_fire;
    logic             rsp_take;
    logic             rsp_push;
    logic             pop;
    logic             fifo_nonempty;
    logic [CNT_W:0]   credit_used;
    logic [31:0]      redirect_tgt;

    assign redirect_tgt  = redirect_pc & WORD_MSK;
    assign fifo_nonempty = (count_q != '0);

    // In-flight fetches plus buffered entries may never exceed the buffer size.
    assign credit_used    = (CNT_W+1)'(outst_q) + (CNT_W+1)'(count_q);
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = pc_q;

    assign id_valid = !rst && fifo_nonempty;
    assign id_inst  = fifo_nonempty ? fifo_q[rd_ptr_q].inst : NOP_INST;
    assign id_pc    = fifo_nonempty ? fifo_q[rd_ptr_q].pc   : rsp_pc_q;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_take = imem_rsp_valid && (outst_q != '0);
    assign rsp_push = rsp_take && (drop_q == '0) && !redirect_valid;
    assign pop      = id_valid && id_ready && !redirect_valid;

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outst_d  = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
        drop_d   = drop_q;
        count_d  = count_q + CNT_W'(rsp_push) - CNT_W'(pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
        if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
        end
        if (rsp_push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Every fetch still in flight after this cycle belongs to the old stream.
        if (redirect_valid) begin
            pc_d     = redirect_tgt;
            rsp_pc_d = redirect_tgt;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            drop_d   = outst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= PC_RST;
            rsp_pc_q <= PC_RST;
            outst_q  <= '0;
            drop_q   <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Buffer storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (rsp_push) begin
            fifo_q[wr_ptr_q].inst <= imem_rsp_data;
            fifo_q[wr_ptr_q].pc   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-configurable memory and an epoch-tagged stream model
// predict request, delivery and redirect behaviour cycle by cycle.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int unsigned ep; int unsigned due; } pend_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

    pend_t       pend[$];
    ent_t        mbuf[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_inst[$];
    logic [31:0] req_log[$];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned epoch = 0;
    int unsigned last_due = 0;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned req_cnt = 0;
    logic [31:0] exp_req = RST_PC;
    logic [31:0] next_rsp = RST_PC;
    logic        cur_rsp_real = 1'b0;
    int unsigned cur_rsp_ep = 0;
    logic        spur = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // One clock: check outputs at negedge against the model, advance it, then drive memory.
    task automatic tick();
        logic        exp_rv, exp_iv, req_hs;
        logic [31:0] e_inst, e_pc, hs_addr;
        int unsigned ep_now, due, lat;
        pend_t       p;
        ent_t        e;
        @(negedge clk);
        ep_now = epoch;
        exp_rv = !rst && !redirect_valid &&
                 ((pend.size() + (cur_rsp_real ? 1 : 0) + mbuf.size()) < DEPTH);
        n_vec++;
        if (imem_req_valid !== exp_rv) begin
            n_err++;
            $display("FAIL req_valid cyc %0d: got %b expected %b", cyc, imem_req_valid, exp_rv);
        end
        if (exp_rv && imem_req_valid === 1'b1) begin
            n_vec++;
            if (imem_req_addr !== exp_req) begin
                n_err++;
                $display("FAIL req_addr cyc %0d: got %h expected %h", cyc, imem_req_addr, exp_req);
            end
        end
        exp_iv = !rst && (mbuf.size() > 0);
        n_vec++;
        if (id_valid !== exp_iv) begin
            n_err++;
            $display("FAIL id_valid cyc %0d: got %b expected %b", cyc, id_valid, exp_iv);
        end
        if (!rst) begin
            e_inst = NOP;
            e_pc   = next_rsp;
            if (mbuf.size() > 0) begin
                e_inst = mbuf[0].inst;
                e_pc   = mbuf[0].pc;
            end
            n_vec++;
            if (id_inst !== e_inst || id_pc !== e_pc) begin
                n_err++;
                $display("FAIL id_head cyc %0d: got inst %h pc %h expected inst %h pc %h",
                         cyc, id_inst, id_pc, e_inst, e_pc);
            end
        end
        req_hs  = (imem_req_valid === 1'b1) && imem_req_ready;
        hs_addr = imem_req_addr;
        if (!rst && id_valid === 1'b1 && id_ready && !redirect_valid) begin
            dlv_pc.push_back(id_pc);
            dlv_inst.push_back(id_inst);
        end
        if (rst) begin
            mbuf.delete();
            exp_req  = RST_PC;
            next_rsp = RST_PC;
            epoch++;
        end else begin
            if (exp_iv && id_ready && !redirect_valid) void'(mbuf.pop_front());
            if (cur_rsp_real && !redirect_valid && cur_rsp_ep == epoch) begin
                e.inst = imem_rsp_data;
                e.pc   = next_rsp;
                mbuf.push_back(e);
                next_rsp = next_rsp + 32'd4;
            end
            if (redirect_valid) begin
                mbuf.delete();
                epoch++;
                exp_req  = {redirect_pc[31:2], 2'b00};
                next_rsp = {redirect_pc[31:2], 2'b00};
            end
            if (req_hs) begin
                req_log.push_back(hs_addr);
                req_cnt++;
                exp_req = exp_req + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (req_hs) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat - 1;
            if (due < last_due) due = last_due;
            last_due = due;
            p.addr = hs_addr;
            p.ep   = ep_now;
            p.due  = due;
            pend.push_back(p);
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            cur_rsp_real   = 1'b1;
            cur_rsp_ep     = pend[0].ep;
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = spur;
            imem_rsp_data  = spur ? 32'hBAD0_BAD0 : $urandom;
            cur_rsp_real   = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        spur = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 60 && (pend.size() > 0 || cur_rsp_real); i++) tick();
        n_vec++;
        if (pend.size() > 0 || cur_rsp_real) begin
            n_err++;
            $display("FAIL reset_drain: got %0d pending expected 0", pend.size());
        end
        rst = 1'b0;
        dlv_pc.delete();
        dlv_inst.delete();
        req_log.delete();
        req_cnt = 0;
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        do_reset();
        #1;
        n_vec++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_req: got v%b a%h iv%b expected v1 a%h iv0",
                     imem_req_valid, imem_req_addr, id_valid, RST_PC);
        end
        n_vec++;
        if (id_inst !== NOP || id_pc !== RST_PC) begin
            n_err++;
            $display("FAIL reset_id: got %h/%h expected %h/%h", id_inst, id_pc, NOP, RST_PC);
        end
        tick();
    endtask

    task automatic test_stream();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        do_reset();
        repeat (30) tick();
        n_vec++;
        if (dlv_pc.size() < 15) begin
            n_err++;
            $display("FAIL stream_count: got %0d expected >= 15", dlv_pc.size());
        end
        for (int i = 0; i < dlv_pc.size(); i++) begin
            n_vec++;
            if (dlv_pc[i] !== RST_PC + 32'(4 * i) || dlv_inst[i] !== mem_word(RST_PC + 32'(4 * i))) begin
                n_err++;
                $display("FAIL stream_seq[%0d]: got %h/%h expected pc %h", i, dlv_pc[i], dlv_inst[i],
                         RST_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1; id_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        #1;
        n_vec++;
        if (req_cnt != 2 || imem_req_valid !== 1'b0 || id_valid !== 1'b1 || id_pc !== RST_PC) begin
            n_err++;
            $display("FAIL bp_hold: got reqs %0d v%b iv%b pc %h expected reqs 2 v0 iv1 pc %h",
                     req_cnt, imem_req_valid, id_valid, id_pc, RST_PC);
        end
        id_ready = 1'b1;
        repeat (10) tick();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (dlv_pc.size() <= i || dlv_pc[i] !== RST_PC + 32'(4 * i)) begin
                n_err++;
                $display("FAIL bp_release[%0d]: got %0d entries expected pc %h", i, dlv_pc.size(),
                         RST_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_latency();
        lat_min = 3; lat_max = 3;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        do_reset();
        repeat (2) tick();
        #1;
        n_vec++;
        if (imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rdl_credit: got %b expected 0", imem_req_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2002;
        req_log.delete();
        dlv_pc.delete();
        dlv_inst.delete();
        tick();
        redirect_valid = 1'b0;
        #1;
        n_vec++;
        if (id_valid !== 1'b0 || id_pc !== 32'h2000) begin
            n_err++;
            $display("FAIL rdl_after: got iv%b pc %h expected iv0 pc 00002000", id_valid, id_pc);
        end
        for (int i = 0; i < 30 && dlv_pc.size() == 0; i++) tick();
        n_vec++;
        if (req_log.size() == 0 || req_log[0] !== 32'h2000) begin
            n_err++;
            $display("FAIL rdl_first_req: got %0d reqs expected first addr 00002000", req_log.size());
        end
        n_vec++;
        if (dlv_pc.size() == 0 || dlv_pc[0] !== 32'h2000 || dlv_inst[0] !== mem_word(32'h2000)) begin
            n_err++;
            $display("FAIL rdl_first_dlv: got %0d deliveries expected pc 00002000 inst %h",
                     dlv_pc.size(), mem_word(32'h2000));
        end
        repeat (6) tick();
    endtask

    task automatic test_redirect_collision();
        logic found;
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = cur_rsp_real && (mbuf.size() > 0);
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL col_setup: got no collision cycle expected one within 20");
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_3000;
        #1;
        n_vec++;
        if (id_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL col_cycle: got iv%b rv%b expected iv1 rv0", id_valid, imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_vec++;
        if (id_valid !== 1'b0 || id_inst !== NOP || id_pc !== 32'h3000) begin
            n_err++;
            $display("FAIL col_flush: got iv%b %h/%h expected iv0 %h/00003000", id_valid, id_inst, id_pc, NOP);
        end
        n_vec++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3000) begin
            n_err++;
            $display("FAIL col_req: got v%b a%h expected v1 a00003000", imem_req_valid, imem_req_addr);
        end
        repeat (6) tick();
    endtask

    task automatic test_stall();
        lat_min = 2; lat_max = 2;
        imem_req_ready = 1'b0; id_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
                n_err++;
                $display("FAIL stall[%0d]: got v%b a%h expected v1 a%h", i, imem_req_valid, imem_req_addr, RST_PC);
            end
            tick();
        end
        n_vec++;
        if (id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_push: got iv%b expected iv0", id_valid);
        end
        imem_req_ready = 1'b1;
        repeat (10) tick();
        n_vec++;
        if (dlv_pc.size() == 0 || dlv_pc[0] !== RST_PC) begin
            n_err++;
            $display("FAIL stall_resume: got %0d deliveries expected first pc %h", dlv_pc.size(), RST_PC);
        end
    endtask

    task automatic test_wrap();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        req_log.delete();
        dlv_pc.delete();
        repeat (12) tick();
        n_vec++;
        if (req_log.size() < 3 || req_log[1] !== 32'hFFFF_FFFC || req_log[2] !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_req: got %0d reqs expected FFFFFFF8 FFFFFFFC 00000000", req_log.size());
        end
        n_vec++;
        if (dlv_pc.size() < 3 || dlv_pc[1] !== 32'hFFFF_FFFC || dlv_pc[2] !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_dlv: got %0d deliveries expected FFFFFFFC then 00000000", dlv_pc.size());
        end
    endtask

    task automatic test_mid_reset();
        lat_min = 2; lat_max = 2;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        do_reset();
        repeat (7) tick();
        rst = 1'b1;
        tick();
        #1;
        n_vec++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_inst !== NOP || id_pc !== RST_PC) begin
            n_err++;
            $display("FAIL midrst: got rv%b iv%b %h/%h expected rv0 iv0 %h/%h",
                     imem_req_valid, id_valid, id_inst, id_pc, NOP, RST_PC);
        end
        do_reset();
        #1;
        n_vec++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            n_err++;
            $display("FAIL midrst_restart: got v%b a%h expected v1 a%h", imem_req_valid, imem_req_addr, RST_PC);
        end
        repeat (5) tick();
    endtask

    task automatic test_spurious();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b0; id_ready = 1'b1;
        do_reset();
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        #1;
        n_vec++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            n_err++;
            $display("FAIL spur_state: got iv%b rv%b a%h expected iv0 rv1 a%h",
                     id_valid, imem_req_valid, imem_req_addr, RST_PC);
        end
        imem_req_ready = 1'b1;
        repeat (8) tick();
        n_vec++;
        if (dlv_pc.size() == 0 || dlv_pc[0] !== RST_PC || dlv_inst[0] !== mem_word(RST_PC)) begin
            n_err++;
            $display("FAIL spur_first: got %0d deliveries expected pc %h inst %h", dlv_pc.size(),
                     RST_PC, mem_word(RST_PC));
        end
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 4;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(0, 99) < 75);
            id_ready       = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 3);
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        repeat (20) tick();
        n_vec++;
        if (dlv_pc.size() < 300) begin
            n_err++;
            $display("FAIL rand_progress: got %0d deliveries expected >= 300", dlv_pc.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_latency();
        test_redirect_collision();
        test_stall();
        test_wrap();
        test_mid_reset();
        test_spurious();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
